pipeline_regs: RTL and testbench
================================

# pipeline_regs

Inter-stage register bank for the 5-stage pipelined processor: IF/ID, ID/EX, EX/MEM and MEM/WB. It consumes the per-register `pipeline_lock` and `pipeline_clear` vectors produced by the pipeline controller, holds, advances, flushes or bubbles each register, and tracks per-register valid bits. It also keeps stall, flush and retire counters and reports a sticky error when the controller issues a lock pattern that would silently lose an instruction.

## Interface
- `W0`, 64: IF/ID payload width (PC + instruction).
- `W1`, 160: ID/EX payload width.
- `W2`, 112: EX/MEM payload width.
- `W3`, 72: MEM/WB payload width.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pipeline_lock`  in  4  per-register write enable; bit 0 = IF/ID … bit 3 = MEM/WB; 1 = normal, 0 = hold.
- `pipeline_clear`  in  4  per-register flush; same bit order; 1 = clear.
- `if_valid`  in  1  IF stage presents a real instruction.
- `d0`..`d3`  in  W0..W3  next payload from IF, ID, EX and MEM logic respectively.
- `q0`..`q3`  out  W0..W3  registered payloads.
- `v0`..`v3`  out  1  valid bit of each register.
- `stall_cnt`  out  CNT_W  cycles with any lock bit = 0.
- `flush_cnt`  out  CNT_W  cycles with any clear bit = 1.
- `retire_cnt`  out  CNT_W  valid instructions leaving MEM/WB.
- `overrun_err`  out  1  sticky: controller lock pattern dropped a valid instruction.

## Operation
- Upstream valid per register: u0 = `if_valid`; u_i = v_{i-1} for i = 1..3.
- Per register i at each rising edge, in priority order:
  1. `pipeline_clear[i]`=1: q_i←0, v_i←0. Clear wins over lock.
  2. `pipeline_lock[i]`=0: hold q_i and v_i.
  3. i>0 and `pipeline_lock[i-1]`=0: insert a bubble, q_i←0, v_i←0. The upstream register is held, so its content must not be duplicated.
  4. Otherwise: q_i←d_i, v_i←u_i.
- Overrun: set `overrun_err` at an edge where, for some i in 1..3, `pipeline_lock[i]`=0, `pipeline_lock[i-1]`=1, `pipeline_clear[i-1]`=0 and v_{i-1}=1. In that case register i-1 is overwritten before its content was consumed. The data update still proceeds as specified above. Only reset clears `overrun_err`.
- Counters:
  - `stall_cnt` +1 when `pipeline_lock`≠4'b1111.
  - `flush_cnt` +1 when `pipeline_clear`≠0.
  - `retire_cnt` +1 when v3=1 and (`pipeline_lock[3]`=1 or `pipeline_clear[3]`=1), i.e. whenever MEM/WB content is replaced.
  - All counters saturate at all-ones; no wrap.
- Reset (`reset_n`=0, asynchronous): every q_i=0, every v_i=0, all counters 0, `overrun_err`=0. Reset asserted mid-stall or mid-flush discards everything immediately. The first update happens on the first rising edge after deassertion.

## Timing
- Register latency is 1 cycle: d_i sampled at edge k appears on q_i after edge k.
- `pipeline_lock` and `pipeline_clear` are sampled only at the rising edge. They must be stable before the edge; the controller's assignment delay is irrelevant to this block.
- Counter and `overrun_err` updates are visible the cycle after the triggering edge.
- Simultaneous lock[i]=0 and clear[i]=1 on the same register: the clear is applied.
- Branch flush 4'b0011 with lock 4'b1111: IF/ID and ID/EX become bubbles; EX/MEM takes d2, so the branch instruction itself proceeds.
- Load-use stall 4'b1110: IF/ID holds; ID/EX bubbles; EX/MEM and MEM/WB advance.

## Structure
- Shared package `pipeline_pkg`:
  - stage index constants `IFID`=0, `IDEX`=1, `EXMEM`=2, `MEMWB`=3;
  - `LOCK_ALL`=4'b1111;
  - `CLEAR_NONE`=4'b0000.
  The controller and this block both use this package.
- One sub-module, `pipe_stage_reg`, parameterized on width. It implements the per-register priority (clear, hold, bubble, load) and the valid bit, and is instantiated 4 times.
- Counters and the overrun check live in the top level.

## Test plan
- Reset then free-run (lock=1111, clear=0000, `if_valid`=1, d0=0x1…): after 4 edges v0..v3=1; q3 carries the first MEM payload; `retire_cnt`=1 after edge 5.
- Branch (clear=0011 for 1 cycle while the pipe is full): v0=v1=0 next cycle, q0=q1=0; v2 and v3 unchanged-advanced; `flush_cnt`=1.
- Load-use (lock=1110 for 2 cycles): q0 is constant across both cycles; v1=0 for 2 cycles; `stall_cnt`=2; `overrun_err`=0.
- Illegal lock 0111 with v2=1: `overrun_err`=1 after the edge and it stays 1 after lock returns to 1111; it is cleared only by `reset_n`=0.
- Saturation (force a 1-cycle stall 65 536+ times with CNT_W=16): `stall_cnt` stays at 0xFFFF.
- Asynchronous reset pulsed between edges during a stall: all v_i, q_i, counters and `overrun_err` read 0 before the next rising edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline controller and the inter-stage register bank.
package pipeline_pkg;
  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  localparam logic [3:0] LOCK_ALL   = 4'b1111;
  localparam logic [3:0] CLEAR_NONE = 4'b0000;
endpackage

// File: rtl/pipe_stage_reg.sv
// One inter-stage register with its valid bit.
// Update priority: clear, hold, bubble, load.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         lock,
  input  logic         up_lock,   // lock of the upstream register; tie high for IF/ID
  input  logic         up_valid,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         v
);

  // Payload and valid update.
  // A bubble is inserted when upstream holds, so its content is not duplicated.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
      v <= 1'b0;
    end else if (clear) begin
      q <= '0;
      v <= 1'b0;
    end else if (!lock) begin
      q <= q;
      v <= v;
    end else if (!up_lock) begin
      q <= '0;
      v <= 1'b0;
    end else begin
      q <= d;
      v <= up_valid;
    end
  end

endmodule

// File: rtl/pipeline_regs.sv
// IF/ID, ID/EX, EX/MEM and MEM/WB register bank with statistics and an overrun check.
module pipeline_regs
  import pipeline_pkg::*;
#(
  parameter int W0    = 64,
  parameter int W1    = 160,
  parameter int W2    = 112,
  parameter int W3    = 72,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       pipeline_lock,
  input  logic [3:0]       pipeline_clear,
  input  logic             if_valid,
  input  logic [W0-1:0]    d0,
  input  logic [W1-1:0]    d1,
  input  logic [W2-1:0]    d2,
  input  logic [W3-1:0]    d3,
  output logic [W0-1:0]    q0,
  output logic [W1-1:0]    q1,
  output logic [W2-1:0]    q2,
  output logic [W3-1:0]    q3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             overrun_err
);

  logic [3:0] v;
  logic [3:0] up_valid;
  logic [3:0] up_lock;
  logic       overrun_hit;

  assign v        = {v3, v2, v1, v0};
  assign up_valid = {v[2:0], if_valid};
  assign up_lock  = {pipeline_lock[2:0], 1'b1};

  pipe_stage_reg #(.W(W0)) u_ifid (
    .clock(clock), .reset_n(reset_n),
    .clear(pipeline_clear[IFID]), .lock(pipeline_lock[IFID]),
    .up_lock(up_lock[IFID]), .up_valid(up_valid[IFID]),
    .d(d0), .q(q0), .v(v0)
  );

  pipe_stage_reg #(.W(W1)) u_idex (
    .clock(clock), .reset_n(reset_n),
    .clear(pipeline_clear[IDEX]), .lock(pipeline_lock[IDEX]),
    .up_lock(up_lock[IDEX]), .up_valid(up_valid[IDEX]),
    .d(d1), .q(q1), .v(v1)
  );

  pipe_stage_reg #(.W(W2)) u_exmem (
    .clock(clock), .reset_n(reset_n),
    .clear(pipeline_clear[EXMEM]), .lock(pipeline_lock[EXMEM]),
    .up_lock(up_lock[EXMEM]), .up_valid(up_valid[EXMEM]),
    .d(d2), .q(q2), .v(v2)
  );

  pipe_stage_reg #(.W(W3)) u_memwb (
    .clock(clock), .reset_n(reset_n),
    .clear(pipeline_clear[MEMWB]), .lock(pipeline_lock[MEMWB]),
    .up_lock(up_lock[MEMWB]), .up_valid(up_valid[MEMWB]),
    .d(d3), .q(q3), .v(v3)
  );

  // A valid upstream register that advances into a held register is lost.
  always_comb begin
    overrun_hit = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (!pipeline_lock[i] && pipeline_lock[i-1] && !pipeline_clear[i-1] && v[i-1])
        overrun_hit = 1'b1;
    end
  end

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         overrun_err <= 1'b0;
    else if (overrun_hit) overrun_err <= 1'b1;
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (pipeline_lock != LOCK_ALL && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (pipeline_clear != CLEAR_NONE && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
      if (v3 && (pipeline_lock[MEMWB] || pipeline_clear[MEMWB]) && retire_cnt != '1)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_regs.sv
// Scoreboard bench for pipeline_regs: a behavioural model predicts each edge.
module tb_pipeline_regs;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [3:0]    pipeline_lock;
  logic [3:0]    pipeline_clear;
  logic          if_valid;
  logic [63:0]   d0;
  logic [159:0]  d1;
  logic [111:0]  d2;
  logic [71:0]   d3;
  logic [63:0]   q0;
  logic [159:0]  q1;
  logic [111:0]  q2;
  logic [71:0]   q3;
  logic          v0, v1, v2, v3;
  logic [15:0]   stall_cnt, flush_cnt, retire_cnt;
  logic          overrun_err;

  typedef struct packed {
    logic [63:0]  q0;
    logic [159:0] q1;
    logic [111:0] q2;
    logic [71:0]  q3;
    logic [3:0]   v;
    logic [15:0]  st;
    logic [15:0]  fl;
    logic [15:0]  rt;
    logic         ov;
  } exp_t;

  exp_t m;
  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  pipeline_regs dut (
    .clock(clock), .reset_n(reset_n),
    .pipeline_lock(pipeline_lock), .pipeline_clear(pipeline_clear),
    .if_valid(if_valid),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt),
    .overrun_err(overrun_err)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = clear, 1 = hold, 2 = bubble, 3 = load
  function automatic int act(input int i, input logic [3:0] lk, input logic [3:0] cl);
    if (cl[i]) return 0;
    if (!lk[i]) return 1;
    if (i > 0 && !lk[i-1]) return 2;
    return 3;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  task automatic compare_all(input exp_t e);
    check("q0", {96'd0, q0}, {96'd0, e.q0});
    check("q1", q1, e.q1);
    check("q2", {48'd0, q2}, {48'd0, e.q2});
    check("q3", {88'd0, q3}, {88'd0, e.q3});
    check("v", {156'd0, v3, v2, v1, v0}, {156'd0, e.v});
    check("stall_cnt", {144'd0, stall_cnt}, {144'd0, e.st});
    check("flush_cnt", {144'd0, flush_cnt}, {144'd0, e.fl});
    check("retire_cnt", {144'd0, retire_cnt}, {144'd0, e.rt});
    check("overrun_err", {159'd0, overrun_err}, {159'd0, e.ov});
  endtask

  // Drive one cycle, predict its result, then compare after the edge.
  task automatic step(input logic [3:0] lk, input logic [3:0] cl, input logic ifv);
    exp_t         e;
    logic [159:0] r;
    logic [3:0]   u;
    int           a;
    pipeline_lock  = lk;
    pipeline_clear = cl;
    if_valid       = ifv;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d2 = r[111:0];
    r  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d3 = r[71:0];
    e = m;
    u = {m.v[2:0], ifv};
    a = act(0, lk, cl); e.q0 = (a == 1) ? m.q0 : (a == 3) ? d0 : '0;
    a = act(1, lk, cl); e.q1 = (a == 1) ? m.q1 : (a == 3) ? d1 : '0;
    a = act(2, lk, cl); e.q2 = (a == 1) ? m.q2 : (a == 3) ? d2 : '0;
    a = act(3, lk, cl); e.q3 = (a == 1) ? m.q3 : (a == 3) ? d3 : '0;
    for (int i = 0; i < 4; i++) begin
      a = act(i, lk, cl);
      e.v[i] = (a == 1) ? m.v[i] : (a == 3) ? u[i] : 1'b0;
    end
    e.st = sat(m.st, lk != 4'b1111);
    e.fl = sat(m.fl, cl != 4'b0000);
    e.rt = sat(m.rt, m.v[3] && (lk[3] || cl[3]));
    for (int i = 1; i < 4; i++)
      if (!lk[i] && lk[i-1] && !cl[i-1] && m.v[i-1]) e.ov = 1'b1;
    sbq.push_back(e);
    m = e;
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 160'd0, 160'd1);
    end else begin
      e = sbq.pop_front();
      compare_all(e);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    pipeline_lock  = 4'b1111;
    pipeline_clear = 4'b0000;
    if_valid       = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    m = '0;
    repeat (2) @(posedge clock);
    #1;
    compare_all(m);                 // reset state
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // Free-run fill
    repeat (4) step(4'b1111, 4'b0000, 1'b1);
    check("fill_v", {156'd0, v3, v2, v1, v0}, 160'hF);
    step(4'b1111, 4'b0000, 1'b1);
    check("first_retire", {144'd0, retire_cnt}, 160'd1);

    // Branch flush
    step(4'b1111, 4'b0011, 1'b1);
    check("branch_v", {156'd0, v3, v2, v1, v0}, 160'hC);
    check("branch_flush", {144'd0, flush_cnt}, 160'd1);
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);

    // Load-use stall
    step(4'b1110, 4'b0000, 1'b1);
    step(4'b1110, 4'b0000, 1'b1);
    check("ldu_v1", {159'd0, v1}, 160'd0);
    check("ldu_stall", {144'd0, stall_cnt}, 160'd2);
    check("ldu_overrun", {159'd0, overrun_err}, 160'd0);
    repeat (3) step(4'b1111, 4'b0000, 1'b1);

    // Clear wins over lock on the same register
    step(4'b1011, 4'b0100, 1'b1);
    repeat (3) step(4'b1111, 4'b0000, 1'b1);

    // Illegal lock drops EX/MEM content
    step(4'b0111, 4'b0000, 1'b1);
    check("ovr_set", {159'd0, overrun_err}, 160'd1);
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b1);
    check("ovr_sticky", {159'd0, overrun_err}, 160'd1);

    // Asynchronous reset between edges during a stall
    pipeline_lock = 4'b1110;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    m = '0;
    compare_all(m);
    #1;
    reset_n = 1'b1;
    #1;

    // Saturation of the stall counter
    repeat (65540) step(4'b1110, 4'b0000, 1'b1);
    check("stall_sat", {144'd0, stall_cnt}, 160'hFFFF);
    step(4'b1111, 4'b0001, 1'b1);
    check("stall_sat_hold", {144'd0, stall_cnt}, 160'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
